// File: rtl/virtq_avail_publisher.sv
// Publishes descriptor heads into per-queue virtio avail rings. Each accepted head
// becomes a ring-slot write, an avail-index write, and then a queue notify.
module virtq_avail_publisher #(
    parameter int NUM_Q      = 3,
    parameter int QSIZE_LOG2 = 8
) (
    input  logic                clk,
    input  logic                csr_rst,
    input  logic [NUM_Q*64-1:0] cfg_avail_base,
    input  logic [NUM_Q-1:0]    cfg_queue_enable,
    input  logic                head_valid,
    output logic                head_ready,
    input  logic [1:0]          head_qid,
    input  logic [15:0]         head_idx,
    output logic                mem_wr_valid,
    input  logic                mem_wr_ready,
    output logic [63:0]         mem_wr_addr,
    output logic [15:0]         mem_wr_data,
    output logic                notify_valid,
    input  logic                notify_ready,
    output logic [1:0]          notify_qid,
    output logic [NUM_Q*16-1:0] avail_idx,
    output logic                err_pulse
);
    localparam logic [15:0] SLOT_MASK = 16'((32'd1 << QSIZE_LOG2) - 32'd1);

    typedef enum logic [1:0] {S_IDLE, S_WR_RING, S_WR_IDX, S_NOTIFY} state_t;

    state_t                 r_state;
    logic                   r_head_ready;
    logic                   r_mem_wr_valid;
    logic [63:0]            r_mem_wr_addr;
    logic [15:0]            r_mem_wr_data;
    logic                   r_notify_valid;
    logic [1:0]             r_notify_qid;
    logic                   r_err_pulse;
    logic [1:0]             r_qid;
    logic [63:0]            r_base;
    logic [NUM_Q-1:0][15:0] r_avail_idx;

    logic        w_head_ok;
    logic [63:0] w_head_base;
    logic [15:0] w_head_cur;
    logic [15:0] w_flight_cur;
    logic [63:0] w_ring_addr;

    // Per-queue selection for the offered head and for the head in flight.
    always_comb begin
        w_head_ok    = 1'b0;
        w_head_base  = '0;
        w_head_cur   = '0;
        w_flight_cur = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            if (head_qid == 2'(q)) begin
                w_head_ok   = cfg_queue_enable[q];
                w_head_base = cfg_avail_base[q*64 +: 64];
                w_head_cur  = r_avail_idx[q];
            end
            if (r_qid == 2'(q)) begin
                w_flight_cur = r_avail_idx[q];
            end
        end
    end

    assign w_ring_addr = w_head_base + 64'd4 + {47'd0, w_head_cur & SLOT_MASK, 1'b0};

    always_ff @(posedge clk) begin
        if (csr_rst) begin
            r_state        <= S_IDLE;
            r_head_ready   <= 1'b0;
            r_mem_wr_valid <= 1'b0;
            r_mem_wr_addr  <= '0;
            r_mem_wr_data  <= '0;
            r_notify_valid <= 1'b0;
            r_notify_qid   <= '0;
            r_err_pulse    <= 1'b0;
            r_qid          <= '0;
            r_base         <= '0;
            r_avail_idx    <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            for (int q = 0; q < NUM_Q; q++) begin
                if (!cfg_queue_enable[q] && !(r_state != S_IDLE && r_qid == 2'(q))) begin
                    r_avail_idx[q] <= '0;
                end
            end
            case (r_state)
                S_IDLE: begin
                    r_head_ready <= 1'b1;
                    if (head_valid && r_head_ready) begin
                        if (w_head_ok) begin
                            r_qid          <= head_qid;
                            r_base         <= w_head_base;
                            r_mem_wr_addr  <= w_ring_addr;
                            r_mem_wr_data  <= head_idx;
                            r_mem_wr_valid <= 1'b1;
                            r_head_ready   <= 1'b0;
                            r_state        <= S_WR_RING;
                        end else begin
                            r_err_pulse <= 1'b1;
                        end
                    end
                end
                S_WR_RING: begin
                    if (mem_wr_ready) begin
                        r_mem_wr_addr <= r_base + 64'd2;
                        r_mem_wr_data <= w_flight_cur + 16'd1;
                        r_state       <= S_WR_IDX;
                    end
                end
                S_WR_IDX: begin
                    if (mem_wr_ready) begin
                        r_mem_wr_valid <= 1'b0;
                        r_notify_valid <= 1'b1;
                        r_notify_qid   <= r_qid;
                        r_state        <= S_NOTIFY;
                        // NOTE: the in-flight queue is excluded from the disable clear, so this commit is never lost.
                        for (int q = 0; q < NUM_Q; q++) begin
                            if (r_qid == 2'(q)) begin
                                r_avail_idx[q] <= r_mem_wr_data;
                            end
                        end
                    end
                end
                S_NOTIFY: begin
                    if (notify_ready) begin
                        r_notify_valid <= 1'b0;
                        r_head_ready   <= 1'b1;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign head_ready   = r_head_ready;
    assign mem_wr_valid = r_mem_wr_valid;
    assign mem_wr_addr  = r_mem_wr_addr;
    assign mem_wr_data  = r_mem_wr_data;
    assign notify_valid = r_notify_valid;
    assign notify_qid   = r_notify_qid;
    assign err_pulse    = r_err_pulse;
    assign avail_idx    = r_avail_idx;

endmodule

// File: tb/tb_virtq_avail_publisher.sv
// Bench for virtq_avail_publisher: directed corner cases plus randomized heads and
// stalls, checked against a per-queue avail-index model and the ring address rules.
module tb_virtq_avail_publisher;
    localparam int NUM_Q      = 3;
    localparam int QSIZE_LOG2 = 8;
    localparam int RING       = 1 << QSIZE_LOG2;

    logic                clk = 1'b0;
    logic                csr_rst;
    logic [NUM_Q*64-1:0] cfg_avail_base;
    logic [NUM_Q-1:0]    cfg_queue_enable;
    logic                head_valid;
    logic                head_ready;
    logic [1:0]          head_qid;
    logic [15:0]         head_idx;
    logic                mem_wr_valid;
    logic                mem_wr_ready;
    logic [63:0]         mem_wr_addr;
    logic [15:0]         mem_wr_data;
    logic                notify_valid;
    logic                notify_ready;
    logic [1:0]          notify_qid;
    logic [NUM_Q*16-1:0] avail_idx;
    logic                err_pulse;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_idx [NUM_Q];
    logic [63:0] base_of   [NUM_Q];

    always #5 clk = ~clk;

    assign cfg_avail_base = {base_of[2], base_of[1], base_of[0]};

    virtq_avail_publisher #(.NUM_Q(NUM_Q), .QSIZE_LOG2(QSIZE_LOG2)) dut (
        .clk(clk), .csr_rst(csr_rst), .cfg_avail_base(cfg_avail_base),
        .cfg_queue_enable(cfg_queue_enable), .head_valid(head_valid), .head_ready(head_ready),
        .head_qid(head_qid), .head_idx(head_idx), .mem_wr_valid(mem_wr_valid),
        .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .notify_valid(notify_valid), .notify_ready(notify_ready), .notify_qid(notify_qid),
        .avail_idx(avail_idx), .err_pulse(err_pulse)
    );

    function automatic logic [NUM_Q*16-1:0] model_vec();
        logic [NUM_Q*16-1:0] v;
        for (int q = 0; q < NUM_Q; q++) v[q*16 +: 16] = model_idx[q];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_phase(input string name, input logic [63:0] a, input logic [15:0] d, input int stall);
        for (int c = 0; c <= stall; c++) begin
            mem_wr_ready = (c == stall);
            checks++;
            if (mem_wr_valid !== 1'b1 || notify_valid !== 1'b0 || mem_wr_addr !== a || mem_wr_data !== d) begin
                errors++;
                $display("FAIL %s_write cyc%0d got v=%b nv=%b a=%h d=%h want v=1 nv=0 a=%h d=%h",
                         name, c, mem_wr_valid, notify_valid, mem_wr_addr, mem_wr_data, a, d);
            end
            tick();
        end
        mem_wr_ready = 1'b0;
    endtask

    task automatic notify_phase(input logic [1:0] q, input int stall);
        for (int c = 0; c <= stall; c++) begin
            notify_ready = (c == stall);
            checks++;
            if (notify_valid !== 1'b1 || mem_wr_valid !== 1'b0 || notify_qid !== q) begin
                errors++;
                $display("FAIL notify cyc%0d got nv=%b wv=%b qid=%0d want nv=1 wv=0 qid=%0d",
                         c, notify_valid, mem_wr_valid, notify_qid, q);
            end
            tick();
        end
        notify_ready = 1'b0;
    endtask

    // Offers one head and follows it through ring write, index write and notify.
    task automatic drive_head(input logic [1:0] qid, input logic [15:0] hidx,
                              input int max_stall, input int ring_stall);
        logic        good;
        logic [15:0] cur;
        good = 1'b0;
        if (qid < NUM_Q) good = cfg_queue_enable[qid];
        for (int i = 0; i < 16 && head_ready !== 1'b1; i++) tick();
        checks++;
        if (head_ready !== 1'b1) begin
            errors++;
            $display("FAIL head_ready_before_offer got %b want 1", head_ready);
        end
        head_valid = 1'b1;
        head_qid   = qid;
        head_idx   = hidx;
        tick();
        head_valid = 1'b0;
        if (!good) begin
            checks++;
            if (err_pulse !== 1'b1 || mem_wr_valid !== 1'b0 || head_ready !== 1'b1) begin
                errors++;
                $display("FAIL drop_q%0d got err=%b wv=%b rdy=%b want err=1 wv=0 rdy=1",
                         qid, err_pulse, mem_wr_valid, head_ready);
            end
            tick();
            checks++;
            if (err_pulse !== 1'b0 || mem_wr_valid !== 1'b0 || avail_idx !== model_vec()) begin
                errors++;
                $display("FAIL drop_after_q%0d got err=%b wv=%b idx=%h want err=0 wv=0 idx=%h",
                         qid, err_pulse, mem_wr_valid, avail_idx, model_vec());
            end
            return;
        end
        cur = model_idx[qid];
        mem_phase("ring", base_of[qid] + 64'd4 + 64'(2 * (int'(cur) % RING)), hidx,
                  (ring_stall >= 0) ? ring_stall : int'($urandom_range(max_stall, 0)));
        mem_phase("idx", base_of[qid] + 64'd2, cur + 16'd1, int'($urandom_range(max_stall, 0)));
        model_idx[qid] = cur + 16'd1;
        notify_phase(qid, int'($urandom_range(max_stall, 0)));
        checks++;
        if (head_ready !== 1'b1 || avail_idx !== model_vec()) begin
            errors++;
            $display("FAIL head_done_q%0d got rdy=%b idx=%h want rdy=1 idx=%h",
                     qid, head_ready, avail_idx, model_vec());
        end
    endtask

    task automatic test_reset();
        csr_rst = 1'b1; head_valid = 1'b1; head_qid = 2'd0; head_idx = 16'h5555;
        mem_wr_ready = 1'b1; notify_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (head_ready !== 1'b0 || mem_wr_valid !== 1'b0 || notify_valid !== 1'b0 || err_pulse !== 1'b0 ||
            mem_wr_addr !== 64'd0 || mem_wr_data !== 16'd0 || notify_qid !== 2'd0 || avail_idx !== '0) begin
            errors++;
            $display("FAIL reset_hold got rdy=%b wv=%b nv=%b err=%b a=%h d=%h q=%0d idx=%h want all zero",
                     head_ready, mem_wr_valid, notify_valid, err_pulse, mem_wr_addr, mem_wr_data, notify_qid, avail_idx);
        end
        csr_rst = 1'b0; head_valid = 1'b0; mem_wr_ready = 1'b0; notify_ready = 1'b0;
        tick();
        checks++;
        if (head_ready !== 1'b1 || mem_wr_valid !== 1'b0 || notify_valid !== 1'b0 || avail_idx !== '0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b wv=%b nv=%b idx=%h want rdy=1 wv=0 nv=0 idx=0",
                     head_ready, mem_wr_valid, notify_valid, avail_idx);
        end
    endtask

    task automatic test_basic();
        drive_head(2'd0, 16'h0005, 0, -1);
        checks++;
        if (avail_idx[15:0] !== 16'h0001) begin
            errors++;
            $display("FAIL basic_avail_q0 got %h want 0001", avail_idx[15:0]);
        end
    endtask

    task automatic test_ring_wrap();
        for (int i = 0; i < 255; i++) drive_head(2'd1, 16'($urandom), 1, -1);
        checks++;
        if (avail_idx[31:16] !== 16'h00FF) begin
            errors++;
            $display("FAIL wrap_pre_q1 got %h want 00FF", avail_idx[31:16]);
        end
        drive_head(2'd1, 16'h0ABC, 0, 0);
        checks++;
        if (avail_idx[31:16] !== 16'h0100) begin
            errors++;
            $display("FAIL wrap_post_q1 got %h want 0100", avail_idx[31:16]);
        end
        drive_head(2'd1, 16'h0DEF, 0, 0);
    endtask

    task automatic test_idx_wrap();
        model_idx[2] = 16'hFFFF;
        force dut.r_avail_idx = {model_idx[2], model_idx[1], model_idx[0]};
        head_valid = 1'b1; head_qid = 2'd2; head_idx = 16'h7777;
        tick();
        head_valid = 1'b0;
        checks++;
        if (mem_wr_valid !== 1'b1 || mem_wr_addr !== base_of[2] + 64'd510 + 64'd4 || mem_wr_data !== 16'h7777) begin
            errors++;
            $display("FAIL idxwrap_ring got v=%b a=%h d=%h want v=1 a=%h d=7777",
                     mem_wr_valid, mem_wr_addr, mem_wr_data, base_of[2] + 64'd514);
        end
        mem_wr_ready = 1'b1;
        tick();
        mem_wr_ready = 1'b0;
        release dut.r_avail_idx;
        checks++;
        if (mem_wr_valid !== 1'b1 || mem_wr_addr !== base_of[2] + 64'd2 || mem_wr_data !== 16'h0000) begin
            errors++;
            $display("FAIL idxwrap_idx got v=%b a=%h d=%h want v=1 a=%h d=0000",
                     mem_wr_valid, mem_wr_addr, mem_wr_data, base_of[2] + 64'd2);
        end
        mem_wr_ready = 1'b1;
        tick();
        mem_wr_ready = 1'b0;
        model_idx[2] = 16'h0000;
        checks++;
        if (notify_valid !== 1'b1 || notify_qid !== 2'd2 || avail_idx[47:32] !== 16'h0000) begin
            errors++;
            $display("FAIL idxwrap_notify got nv=%b q=%0d idx2=%h want nv=1 q=2 idx2=0000",
                     notify_valid, notify_qid, avail_idx[47:32]);
        end
        notify_phase(2'd2, 0);
        checks++;
        if (head_ready !== 1'b1 || avail_idx !== model_vec()) begin
            errors++;
            $display("FAIL idxwrap_done got rdy=%b idx=%h want rdy=1 idx=%h", head_ready, avail_idx, model_vec());
        end
    endtask

    task automatic test_backpressure();
        drive_head(2'd0, 16'h1357, 2, 5);
    endtask

    task automatic test_drop();
        drive_head(2'd3, 16'hBEEF, 0, -1);
        cfg_queue_enable[1] = 1'b0;
        tick();
        model_idx[1] = 16'h0000;
        checks++;
        if (avail_idx !== model_vec()) begin
            errors++;
            $display("FAIL disable_clear_q1 got %h want %h", avail_idx, model_vec());
        end
        drive_head(2'd1, 16'h1234, 0, -1);
        cfg_queue_enable[1] = 1'b1;
    endtask

    task automatic test_disable_inflight();
        logic [15:0] cur;
        cur = model_idx[0];
        head_valid = 1'b1; head_qid = 2'd0; head_idx = 16'h0A0A;
        tick();
        head_valid = 1'b0;
        cfg_queue_enable[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_wr_valid !== 1'b1 || avail_idx[15:0] !== cur) begin
                errors++;
                $display("FAIL inflight_hold cyc%0d got wv=%b idx0=%h want wv=1 idx0=%h", i, mem_wr_valid, avail_idx[15:0], cur);
            end
            tick();
        end
        mem_wr_ready = 1'b1;
        repeat (2) tick();
        mem_wr_ready = 1'b0;
        checks++;
        if (notify_valid !== 1'b1 || avail_idx[15:0] !== cur + 16'd1) begin
            errors++;
            $display("FAIL inflight_commit got nv=%b idx0=%h want nv=1 idx0=%h", notify_valid, avail_idx[15:0], cur + 16'd1);
        end
        notify_ready = 1'b1;
        tick();
        notify_ready = 1'b0;
        tick();
        model_idx[0] = 16'h0000;
        checks++;
        if (head_ready !== 1'b1 || avail_idx !== model_vec()) begin
            errors++;
            $display("FAIL inflight_clear got rdy=%b idx=%h want rdy=1 idx=%h", head_ready, avail_idx, model_vec());
        end
        cfg_queue_enable[0] = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  q;
        logic [15:0] h;
        mem_wr_ready = 1'b1;
        notify_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            q = 2'(k % NUM_Q);
            h = 16'($urandom);
            head_valid = 1'b1; head_qid = q; head_idx = h;
            checks++;
            if (head_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready k%0d got %b want 1", k, head_ready);
            end
            tick();
            checks++;
            if (mem_wr_valid !== 1'b1 || head_ready !== 1'b0 ||
                mem_wr_addr !== base_of[q] + 64'd4 + 64'(2 * (int'(model_idx[q]) % RING)) || mem_wr_data !== h) begin
                errors++;
                $display("FAIL b2b_ring k%0d got v=%b rdy=%b a=%h d=%h want v=1 rdy=0 d=%h", k, mem_wr_valid, head_ready, mem_wr_addr, mem_wr_data, h);
            end
            tick();
            checks++;
            if (mem_wr_valid !== 1'b1 || mem_wr_addr !== base_of[q] + 64'd2 || mem_wr_data !== model_idx[q] + 16'd1) begin
                errors++;
                $display("FAIL b2b_idx k%0d got v=%b a=%h d=%h want v=1 d=%h", k, mem_wr_valid, mem_wr_addr, mem_wr_data, model_idx[q] + 16'd1);
            end
            model_idx[q] = model_idx[q] + 16'd1;
            tick();
            checks++;
            if (notify_valid !== 1'b1 || mem_wr_valid !== 1'b0 || notify_qid !== q || head_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b_notify k%0d got nv=%b wv=%b q=%0d rdy=%b want nv=1 wv=0 q=%0d rdy=0", k, notify_valid, mem_wr_valid, notify_qid, head_ready, q);
            end
            tick();
        end
        head_valid = 1'b0;
        mem_wr_ready = 1'b0;
        notify_ready = 1'b0;
        checks++;
        if (head_ready !== 1'b1 || avail_idx !== model_vec()) begin
            errors++;
            $display("FAIL b2b_end got rdy=%b idx=%h want rdy=1 idx=%h", head_ready, avail_idx, model_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) drive_head(2'($urandom_range(3, 0)), 16'($urandom), 3, -1);
    endtask

    task automatic test_reset_mid();
        head_valid = 1'b1; head_qid = 2'd1; head_idx = 16'h4242;
        tick();
        head_valid = 1'b0;
        mem_wr_ready = 1'b1;
        tick();
        mem_wr_ready = 1'b0;
        csr_rst = 1'b1;
        tick();
        for (int q = 0; q < NUM_Q; q++) model_idx[q] = 16'h0000;
        checks++;
        if (mem_wr_valid !== 1'b0 || notify_valid !== 1'b0 || head_ready !== 1'b0 || avail_idx !== '0) begin
            errors++;
            $display("FAIL midreset got wv=%b nv=%b rdy=%b idx=%h want all zero", mem_wr_valid, notify_valid, head_ready, avail_idx);
        end
        csr_rst = 1'b0;
        tick();
        checks++;
        if (head_ready !== 1'b1 || mem_wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle got rdy=%b wv=%b want rdy=1 wv=0", head_ready, mem_wr_valid);
        end
        drive_head(2'd1, 16'h0099, 1, -1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        base_of[0] = 64'h0000_0000_0000_1000;
        base_of[1] = 64'h0000_0000_0000_2000;
        base_of[2] = 64'h0000_0001_0000_3000;
        for (int q = 0; q < NUM_Q; q++) model_idx[q] = 16'h0000;
        cfg_queue_enable = '1;
        head_qid = 2'd0;
        head_idx = 16'h0000;
        test_reset();
        test_basic();
        test_ring_wrap();
        test_idx_wrap();
        test_backpressure();
        test_drop();
        test_disable_inflight();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/virtq_avail_publisher.md
VIRTQ_AVAIL_PUBLISHER -- requirements
Module: virtq_avail_publisher

Interface
REQ-001 SHALL have parameter NUM_Q, default 3: number of virtqueues served.
REQ-002 SHALL have parameter QSIZE_LOG2, default 8: log2 of the ring size, which is the same for all queues.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port csr_rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cfg_avail_base, input, NUM_Q*64: per-queue avail-ring base address; queue q occupies bits [64q+63:64q].
REQ-006 SHALL have port cfg_queue_enable, input, NUM_Q: per-queue enable.
REQ-007 SHALL have port head_valid, input, 1: a descriptor head is offered.
REQ-008 SHALL have port head_ready, output, 1: the offered head is accepted.
REQ-009 SHALL have port head_qid, input, 2: target queue of the offered head.
REQ-010 SHALL have port head_idx, input, 16: descriptor head index to publish.
REQ-011 SHALL have port mem_wr_valid, output, 1: 16-bit memory write request.
REQ-012 SHALL have port mem_wr_ready, input, 1: memory write accepted.
REQ-013 SHALL have port mem_wr_addr, output, 64: byte address of the write.
REQ-014 SHALL have port mem_wr_data, output, 16: write data.
REQ-015 SHALL have port notify_valid, output, 1: queue-notify request toward the device CSR.
REQ-016 SHALL have port notify_ready, input, 1: notify accepted.
REQ-017 SHALL have port notify_qid, output, 2: queue being notified.
REQ-018 SHALL have port avail_idx, output, NUM_Q*16: per-queue published avail index.
REQ-019 SHALL have port err_pulse, output, 1: one-cycle pulse when a head is dropped.

Function
REQ-020 SHALL implement the FSM IDLE -> WR_RING -> WR_IDX -> NOTIFY -> IDLE.
REQ-021 SHALL drive head_ready=1 only in IDLE; a transfer occurs when head_valid && head_ready are both high.
REQ-022 SHALL, on a transfer with head_qid<NUM_Q and the queue enabled, latch qid and head_idx and enter WR_RING.
REQ-023 SHALL, on a transfer with head_qid>=NUM_Q or the queue disabled, drop the head, pulse err_pulse the next cycle, and stay in IDLE.
REQ-024 SHALL, in WR_RING, hold mem_wr_valid=1 with addr = base+4+2*(avail_idx[q] mod 2^QSIZE_LOG2) and data = head_idx; on handshake it SHALL go to WR_IDX.
REQ-025 SHALL, in WR_IDX, hold mem_wr_valid=1 with addr = base+2 and data = avail_idx[q]+1 (16-bit wrap); on handshake it SHALL update avail_idx[q] and go to NOTIFY.
REQ-026 SHALL, in NOTIFY, hold notify_valid=1 with notify_qid=q; on handshake it SHALL return to IDLE.
REQ-027 SHALL keep addr, data and qid stable while a valid signal is high and its ready is low; valid SHALL NOT drop before the handshake.
REQ-028 SHALL register all outputs; a head transfer in cycle T produces mem_wr_valid at T+1.
REQ-029 SHALL, with all readies held at 1, produce ring write at T+1, idx write at T+2, notify at T+3, and head_ready=1 again at T+4 (one head per 4 cycles).
REQ-030 SHALL keep avail_idx a free-running 16-bit counter (0xFFFF -> 0x0000), while the ring slot wraps modulo the ring size.
REQ-031 SHALL clear avail_idx[q] to 0 one cycle after cfg_queue_enable[q] goes low, except while queue q is in flight; in that case the operation completes and the clear happens on return to IDLE.
REQ-032 SHALL never have mem_wr_valid and notify_valid high in the same cycle.

Reset
REQ-033 SHALL, while csr_rst=1 and in the cycle after, hold: state IDLE, head_ready=0 during reset, mem_wr_valid=0, notify_valid=0, err_pulse=0, all avail_idx=0, mem_wr_addr/data=0, notify_qid=0.
REQ-034 SHALL, on reset mid-operation, abandon the operation without completing the handshake and leave the interrupted avail_idx unchanged.

Verification
REQ-035 SHALL test: q0 base 0x1000, size 256, head_idx 0x0005, readies=1 -> write 0x1004<=0x0005, write 0x1002<=0x0001, notify qid 0, avail_idx[0]=1.
REQ-036 SHALL test: avail_idx[1]=0x00FF, base 0x2000 -> ring write to 0x2000+4+2*255=0x2202, idx write 0x0100; next head goes to slot 0 at 0x2004.
REQ-037 SHALL test: avail_idx=0xFFFF -> idx write data 0x0000, and avail_idx wraps to 0.
REQ-038 SHALL test: mem_wr_ready low for 5 cycles during WR_RING -> addr and data stable, no idx write before the handshake, no notify.
REQ-039 SHALL test: head_qid=3, or a disabled queue -> accepted, err_pulse one cycle, no memory write, avail_idx unchanged.
REQ-040 SHALL test: csr_rst asserted in WR_IDX -> valids low the next cycle, avail_idx=0, FSM IDLE, and the next head is processed normally.
